// File: rtl/rvh_l1d_mshr_refill_ctrl.sv
// MSHR valid vector owner and refill line assembler: collects L2 beats, writes the line to L1D, then frees the entry.
// Write request one cycle after the last beat, release pulse the next cycle; refill_rdy_o drops while a line is written back.
module rvh_l1d_mshr_refill_ctrl #(
  parameter int MSHR_NUM   = 4,
  parameter int MSHR_ID_W  = (MSHR_NUM > 1 ? $clog2(MSHR_NUM) : 1),
  parameter int BEAT_W     = 64,
  parameter int BEAT_NUM   = 8,
  parameter int BEAT_CNT_W = $clog2(BEAT_NUM),
  parameter int LINE_W     = BEAT_W * BEAT_NUM
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_vld_i,
  input  logic [MSHR_ID_W-1:0] alloc_id_i,
  output logic [MSHR_NUM-1:0]  mshr_bank_valid_o,
  input  logic                 refill_vld_i,
  output logic                 refill_rdy_o,
  input  logic [MSHR_ID_W-1:0] refill_mshr_id_i,
  input  logic [BEAT_W-1:0]    refill_data_i,
  input  logic                 refill_last_i,
  output logic                 l1d_wr_vld_o,
  input  logic                 l1d_wr_rdy_i,
  output logic [MSHR_ID_W-1:0] l1d_wr_mshr_id_o,
  output logic [LINE_W-1:0]    l1d_wr_data_o,
  output logic                 mshr_release_vld_o,
  output logic [MSHR_ID_W-1:0] mshr_release_id_o,
  output logic                 proto_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_RELEASE
  } state_t;

  localparam logic [BEAT_CNT_W-1:0] LP_CNT_LAST = BEAT_CNT_W'(BEAT_NUM - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [MSHR_ID_W-1:0]   r_id;
  logic [BEAT_CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0]      r_line;
  logic [MSHR_NUM-1:0]    r_valid;
  logic [MSHR_NUM-1:0]    w_valid_nxt;
  logic                   r_rel_vld;
  logic                   r_err;
  logic                   w_acc;
  logic                   w_refill_err;
  logic                   w_alloc_err;
  logic                   w_alloc_hit;
  logic                   w_tgt_invalid;

  assign refill_rdy_o       = (r_state == S_IDLE) || (r_state == S_RECV);
  assign l1d_wr_vld_o       = (r_state == S_WRITE);
  assign w_acc              = refill_vld_i && refill_rdy_o;
  assign mshr_bank_valid_o  = r_valid;
  assign l1d_wr_mshr_id_o   = r_id;
  assign l1d_wr_data_o      = r_line;
  assign mshr_release_vld_o = r_rel_vld;
  assign mshr_release_id_o  = r_id;
  assign proto_err_o        = r_err;

  // Ids beyond MSHR_NUM never match an entry, so they read as invalid.
  always_comb begin
    w_tgt_invalid = 1'b1;
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (refill_mshr_id_i == MSHR_ID_W'(i)) begin
        w_tgt_invalid = !r_valid[i];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_refill_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_nxt  = refill_last_i ? S_WRITE : S_RECV;
          w_refill_err = refill_last_i || w_tgt_invalid;
        end
      end
      S_RECV: begin
        if (w_acc) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_state_nxt = S_WRITE;
            if (!refill_last_i) w_refill_err = 1'b1;
          end else if (refill_last_i) begin
            w_state_nxt  = S_WRITE;
            w_refill_err = 1'b1;
          end
          if (refill_mshr_id_i != r_id) w_refill_err = 1'b1;
        end
      end
      S_WRITE: begin
        if (l1d_wr_rdy_i) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Allocation wins over a same-cycle release of the same entry.
  always_comb begin
    w_valid_nxt = r_valid;
    w_alloc_err = 1'b0;
    w_alloc_hit = 1'b0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (alloc_vld_i && (alloc_id_i == MSHR_ID_W'(i))) begin
        w_alloc_hit    = 1'b1;
        w_valid_nxt[i] = 1'b1;
        if (r_valid[i]) w_alloc_err = 1'b1;
      end else if ((r_state == S_RELEASE) && (r_id == MSHR_ID_W'(i))) begin
        w_valid_nxt[i] = 1'b0;
      end
    end
    if (alloc_vld_i && !w_alloc_hit) w_alloc_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id      <= '0;
      r_cnt     <= '0;
      r_line    <= '0;
      r_valid   <= '0;
      r_rel_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_err     <= r_err | w_refill_err | w_alloc_err;
      r_rel_vld <= (r_state == S_WRITE) && l1d_wr_rdy_i;
      if (w_acc) begin
        if (r_state == S_IDLE) begin
          r_id              <= refill_mshr_id_i;
          r_line[BEAT_W-1:0] <= refill_data_i;
          r_cnt             <= BEAT_CNT_W'(1);
        end else begin
          for (int b = 0; b < BEAT_NUM; b++) begin
            if (r_cnt == BEAT_CNT_W'(b)) begin
              r_line[b*BEAT_W +: BEAT_W] <= refill_data_i;
            end
          end
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (r_state == S_RELEASE) r_cnt <= '0;
    end
  end

endmodule

// File: doc/rvh_l1d_mshr_refill_ctrl.md
Name: rvh_l1d_mshr_refill_ctrl

Overview:
- Owns the MSHR valid vector; this is the release side of the MSHR free-entry allocator.
- Sets an entry's valid bit when the miss path allocates it.
- Collects the L2 refill beats for a pending entry into a line buffer, then writes the full line into the L1D data array.
- Clears the entry's valid bit after that write, which returns the entry to the allocator's free pool.

Parameters:
- MSHR_NUM, 4, number of MSHR entries.
- MSHR_ID_W, (MSHR_NUM>1 ? $clog2(MSHR_NUM) : 1), MSHR id width.
- BEAT_W, 64, refill beat data width.
- BEAT_NUM, 8, beats per cache line (power of two, at least 2).
- BEAT_CNT_W, $clog2(BEAT_NUM), beat counter width.
- LINE_W, BEAT_W*BEAT_NUM, cache line width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_vld_i  in  1  MSHR allocation strobe from the miss path
- alloc_id_i  in  MSHR_ID_W  entry being allocated
- mshr_bank_valid_o  out  MSHR_NUM  per-entry valid vector, fed to the allocator
- refill_vld_i  in  1  refill beat valid
- refill_rdy_o  out  1  refill beat ready
- refill_mshr_id_i  in  MSHR_ID_W  target entry of the beat
- refill_data_i  in  BEAT_W  beat data, beat 0 is the low-order bits
- refill_last_i  in  1  last beat of the line
- l1d_wr_vld_o  out  1  line write request to the data array
- l1d_wr_rdy_i  in  1  data array accepts the write
- l1d_wr_mshr_id_o  out  MSHR_ID_W  entry of the line being written
- l1d_wr_data_o  out  LINE_W  assembled line
- mshr_release_vld_o  out  1  one-cycle release pulse
- mshr_release_id_o  out  MSHR_ID_W  released entry
- proto_err_o  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - mshr_bank_valid_o=0, state=IDLE, beat counter=0, line buffer=0.
  - l1d_wr_vld_o=0, mshr_release_vld_o=0, proto_err_o=0.
  - refill_rdy_o=1 once reset is released.
  - Reset in any state aborts the refill in progress; no release pulse is generated.
- A beat is accepted when refill_vld_i & refill_rdy_o.
- refill_rdy_o = (state==IDLE || state==RECV).
- FSM states: IDLE, RECV, WRITE, RELEASE.
- IDLE:
  - Accepted beat: latch refill_mshr_id_i, write beat 0, set counter=1, go to RECV.
  - If refill_last_i is 1 on this beat, set proto_err_o and go to WRITE anyway.
- RECV:
  - Each accepted beat writes slot[counter] and increments the counter.
  - Beat with counter==BEAT_NUM-1: go to WRITE. If refill_last_i=0 on this beat, set proto_err_o.
  - refill_last_i=1 with counter<BEAT_NUM-1: set proto_err_o and go to WRITE. Unfilled slots keep stale data.
  - A beat whose refill_mshr_id_i differs from the latched id: set proto_err_o. The data is still stored and the latched id is kept.
- WRITE:
  - l1d_wr_vld_o=1; l1d_wr_mshr_id_o and l1d_wr_data_o are held stable until l1d_wr_rdy_i.
  - On the handshake go to RELEASE.
- RELEASE, one cycle:
  - mshr_release_vld_o=1 with the latched id; clear valid[id] at the end of the cycle; return to IDLE.
- Latency with l1d_wr_rdy_i tied high:
  - Last beat accepted in cycle N.
  - Write request in N+1.
  - Release pulse in N+2.
  - mshr_bank_valid_o[id]=0 from N+3.
  - Earliest next beat accepted in N+3.
- Valid vector update, per entry, each cycle:
  - Set when alloc_vld_i and alloc_id_i selects the entry.
  - Cleared on release of that entry.
  - Alloc and release of different ids in the same cycle both take effect.
  - Alloc of an already-valid entry, including the one being released: set wins and proto_err_o is set.
  - Alloc_id_i >= MSHR_NUM: ignored and proto_err_o is set.
- Refill checks:
  - A first beat targeting an entry whose valid bit is 0: proto_err_o is set and the line is processed normally. The release clears an already-clear bit.
- proto_err_o is cleared only by reset.
- All outputs are registered except refill_rdy_o and l1d_wr_vld_o, which decode directly from the state register.

Test Plan:
- Basic refill: reset, alloc id 2, then 8 consecutive beats with data 0x00..0x07 on id 2, last on beat 7, l1d_wr_rdy_i=1 → l1d_wr_data_o={0x07,...,0x00} with id 2 one cycle after the last beat; release pulse on id 2 the following cycle; mshr_bank_valid_o goes 4'b0100→4'b0000; proto_err_o=0.
- Write backpressure: as the basic refill but l1d_wr_rdy_i=0 for 5 cycles → l1d_wr_vld_o and l1d_wr_data_o held for 5 cycles; refill_rdy_o=0 for that whole time; release pulse exactly once after the handshake.
- Concurrent alloc and release: alloc id 1 in the same cycle id 0 is released → valid changes from 4'b0001 to 4'b0010 in one edge; no error.
- Early last: refill_last_i on beat 3 → goes to WRITE after 4 beats; proto_err_o=1; release pulse still issued.
- Mid-line id mismatch and gaps: refill_vld_i toggles to create gaps, and beat 4 carries id 3 instead of 1 → line assembled in beat order; written with id 1; proto_err_o=1.
- Reset mid-refill: assert rst_n=0 after 4 beats → outputs return to reset values immediately; no release pulse; a fresh 8-beat refill after reset completes correctly.
